// File: rtl/axi_write_arbiter_pkg.sv
// Shared types and constants for the AXI4 write-channel arbiter.
package axi_write_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AxSIZE encoding for a full-width beat of the given data width
  function automatic logic [2:0] axi_awsize(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: scan starts one past the last grant.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [IW-1:0]      grant,
  output logic               any_req
);

  logic [IW-1:0] idx;

  // Walk from farthest to nearest so the nearest requester after last_grant wins
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = int'(NUM_REQ); k > 0; k--) begin
      idx = IW'((int'(last_grant) + k) % int'(NUM_REQ));
      if (req[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter sharing one AXI4 write master (AW/W/B) among NUM_REQ
// requesters, one burst outstanding at a time.
// Optional macro AXI_ARB_WLAST_CHECK_EN adds the sticky wlast_err output.
module axi_write_arbiter
  import axi_write_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ            = 2,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 64,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic [NUM_REQ*C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [NUM_REQ*8-1:0]                 s_axi_awlen,
  input  logic [NUM_REQ-1:0]                   s_axi_awvalid,
  output logic [NUM_REQ-1:0]                   s_axi_awready,
  input  logic [NUM_REQ*C_S_AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [NUM_REQ*C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic [NUM_REQ-1:0]                   s_axi_wlast,
  input  logic [NUM_REQ-1:0]                   s_axi_wvalid,
  output logic [NUM_REQ-1:0]                   s_axi_wready,
  output logic [NUM_REQ*2-1:0]                 s_axi_bresp,
  output logic [NUM_REQ-1:0]                   s_axi_bvalid,
  input  logic [NUM_REQ-1:0]                   s_axi_bready,
  output logic [3:0]                           m_axi_awid,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]        m_axi_awaddr,
  output logic [7:0]                           m_axi_awlen,
  output logic [2:0]                           m_axi_awsize,
  output logic [1:0]                           m_axi_awburst,
  output logic                                 m_axi_awvalid,
  input  logic                                 m_axi_awready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        m_axi_wdata,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]      m_axi_wstrb,
  output logic                                 m_axi_wlast,
  output logic                                 m_axi_wvalid,
  input  logic                                 m_axi_wready,
  input  logic [1:0]                           m_axi_bresp,
  input  logic                                 m_axi_bvalid,
  output logic                                 m_axi_bready,
  output logic                                 busy
`ifdef AXI_ARB_WLAST_CHECK_EN
  ,
  output logic                                 wlast_err
`endif
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t        state;
  logic [IW-1:0] grant_q;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] arb_grant;
  logic          any_req;
  logic [7:0]    awlen_q;
  logic [7:0]    beat_q;

  logic [AW-1:0] awaddr_a [NUM_REQ];
  logic [7:0]    awlen_a  [NUM_REQ];
  logic [DW-1:0] wdata_a  [NUM_REQ];
  logic [SW-1:0] wstrb_a  [NUM_REQ];

  // Unpack requester slices; per-slice handshakes only open for the grant
  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_slice
    logic sel;
    assign sel                     = (grant_q == IW'(i));
    assign awaddr_a[i]             = s_axi_awaddr[i*AW +: AW];
    assign awlen_a[i]              = s_axi_awlen[i*8 +: 8];
    assign wdata_a[i]              = s_axi_wdata[i*DW +: DW];
    assign wstrb_a[i]              = s_axi_wstrb[i*SW +: SW];
    assign s_axi_awready[i]        = sel && (state == ST_ADDR) && m_axi_awready;
    assign s_axi_wready[i]         = sel && (state == ST_DATA) && m_axi_wready;
    assign s_axi_bvalid[i]         = sel && (state == ST_RESP) && m_axi_bvalid;
    assign s_axi_bresp[i*2 +: 2]   = (sel && (state == ST_RESP)) ? m_axi_bresp : AXI_RESP_OKAY;
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req        (s_axi_awvalid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .any_req    (any_req)
  );

  // Master-side view of the granted requester
  assign m_axi_awid    = 4'(grant_q);
  assign m_axi_awaddr  = awaddr_a[grant_q];
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = axi_awsize(DW);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awvalid = (state == ST_ADDR);
  assign m_axi_wdata   = wdata_a[grant_q];
  assign m_axi_wstrb   = wstrb_a[grant_q];
  assign m_axi_wlast   = (state == ST_DATA) && (beat_q == awlen_q);
  assign m_axi_wvalid  = (state == ST_DATA) && s_axi_wvalid[grant_q];
  assign m_axi_bready  = (state == ST_RESP) && s_axi_bready[grant_q];
  assign busy          = (state != ST_IDLE);

`ifndef AXI_ARB_WLAST_CHECK_EN
  logic unused_wlast;
  assign unused_wlast = ^s_axi_wlast;
`endif

  // Burst sequencer: grant, address, data beats, response
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      grant_q    <= '0;
      awlen_q    <= '0;
      beat_q     <= '0;
`ifdef AXI_ARB_WLAST_CHECK_EN
      wlast_err  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant_q <= arb_grant;
            awlen_q <= awlen_a[arb_grant];
            state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_axi_awready) begin
            beat_q <= '0;
            state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (m_axi_wvalid && m_axi_wready) begin
`ifdef AXI_ARB_WLAST_CHECK_EN
            if (s_axi_wlast[grant_q] != m_axi_wlast) wlast_err <= 1'b1;
`endif
            if (m_axi_wlast) state  <= ST_RESP;
            else             beat_q <= beat_q + 8'd1;
          end
        end
        ST_RESP: begin
          if (m_axi_bvalid && m_axi_bready) begin
            last_grant <= grant_q;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter with two requesters.
module tb_axi_write_arbiter;

  localparam int NR = 2;
  localparam int DW = 64;
  localparam int AW = 32;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [NR*AW-1:0]  s_axi_awaddr;
  logic [NR*8-1:0]   s_axi_awlen;
  logic [NR-1:0]     s_axi_awvalid;
  logic [NR-1:0]     s_axi_awready;
  logic [NR*DW-1:0]  s_axi_wdata;
  logic [NR*DW/8-1:0] s_axi_wstrb;
  logic [NR-1:0]     s_axi_wlast;
  logic [NR-1:0]     s_axi_wvalid;
  logic [NR-1:0]     s_axi_wready;
  logic [NR*2-1:0]   s_axi_bresp;
  logic [NR-1:0]     s_axi_bvalid;
  logic [NR-1:0]     s_axi_bready;
  logic [3:0]        m_axi_awid;
  logic [AW-1:0]     m_axi_awaddr;
  logic [7:0]        m_axi_awlen;
  logic [2:0]        m_axi_awsize;
  logic [1:0]        m_axi_awburst;
  logic              m_axi_awvalid;
  logic              m_axi_awready;
  logic [DW-1:0]     m_axi_wdata;
  logic [DW/8-1:0]   m_axi_wstrb;
  logic              m_axi_wlast;
  logic              m_axi_wvalid;
  logic              m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid;
  logic              m_axi_bready;
  logic              busy;
`ifdef AXI_ARB_WLAST_CHECK_EN
  logic              wlast_err;
`endif

  int checks = 0;
  int errors = 0;

  axi_write_arbiter #(
    .NUM_REQ            (NR),
    .C_S_AXI_DATA_WIDTH (DW),
    .C_S_AXI_ADDR_WIDTH (AW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .m_axi_awid    (m_axi_awid),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_awsize  (m_axi_awsize),
    .m_axi_awburst (m_axi_awburst),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .busy          (busy)
`ifdef AXI_ARB_WLAST_CHECK_EN
    ,
    .wlast_err     (wlast_err)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    aresetn       = 1'b0;
    s_axi_awaddr  = '0;
    s_axi_awlen   = '0;
    s_axi_awvalid = '0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_wlast   = '0;
    s_axi_wvalid  = '0;
    s_axi_bready  = '0;
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    @(posedge aclk); #1;
    chk_eq("rst_busy", 64'(busy), 64'd0);
    chk_eq("rst_m_awvalid", 64'(m_axi_awvalid), 64'd0);
    chk_eq("rst_m_wvalid", 64'(m_axi_wvalid), 64'd0);
    chk_eq("rst_m_bready", 64'(m_axi_bready), 64'd0);
    chk_eq("rst_s_awready", 64'(s_axi_awready), 64'd0);
    chk_eq("rst_s_bvalid", 64'(s_axi_bvalid), 64'd0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic aw_phase(input int r, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    while (m_axi_awvalid !== 1'b1 && n < 20) begin
      @(posedge aclk); #1;
      n++;
    end
    chk_eq("aw_valid", 64'(m_axi_awvalid), 64'd1);
    chk_eq("aw_id", 64'(m_axi_awid), 64'(r));
    chk_eq("aw_addr", 64'(m_axi_awaddr), 64'(addr));
    chk_eq("aw_len", 64'(m_axi_awlen), 64'(len));
    chk_eq("aw_size", 64'(m_axi_awsize), 64'd3);
    chk_eq("aw_burst", 64'(m_axi_awburst), 64'd1);
    chk_eq("aw_s_ready", 64'(s_axi_awready), 64'(2'b01 << r));
    chk_eq("aw_busy", 64'(busy), 64'd1);
    @(posedge aclk); #1;
    s_axi_awvalid[r] = 1'b0;
  endtask

  // mode 0: master always ready; mode 1: ready pattern 1,0,1,0...
  task automatic w_phase(input int r, input logic [7:0] len, input int mode, input int bad);
    int beats = 0;
    int cyc = 0;
    logic wr;
    logic [63:0] seed;
    seed = 64'hD00D_0000_0000_0000 | 64'(r << 20);
    s_axi_wvalid[r] = 1'b1;
    while (beats <= int'(len) && cyc < 1000) begin
      wr = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      m_axi_wready = wr;
      s_axi_wdata[r*DW +: DW] = seed + 64'(beats);
      s_axi_wstrb[r*8 +: 8]   = 8'(beats) ^ 8'h5A;
      s_axi_wlast[r]          = (beats == int'(len)) ^ (beats == bad);
      #1;
      chk_eq("w_m_valid", 64'(m_axi_wvalid), 64'd1);
      chk_eq("w_s_ready", 64'(s_axi_wready), 64'(wr) << r);
      chk_eq("w_s_awready", 64'(s_axi_awready), 64'd0);
      if (wr) begin
        chk_eq("w_data", m_axi_wdata, seed + 64'(beats));
        chk_eq("w_strb", 64'(m_axi_wstrb), 64'(8'(beats) ^ 8'h5A));
        chk_eq("w_last", 64'(m_axi_wlast), 64'(beats == int'(len)));
        beats++;
      end
      @(posedge aclk); #1;
      cyc++;
    end
    chk_eq("w_beat_count", 64'(beats), 64'(int'(len) + 1));
    m_axi_wready = 1'b1;
    #1;
    chk_eq("w_none_after_last", 64'(m_axi_wvalid), 64'd0);
    s_axi_wvalid[r] = 1'b0;
    s_axi_wlast[r]  = 1'b0;
    m_axi_wready    = 1'b0;
  endtask

  task automatic b_phase(input int r, input logic [1:0] resp);
    s_axi_bready[r] = 1'b1;
    m_axi_bvalid    = 1'b1;
    m_axi_bresp     = resp;
    #1;
    chk_eq("b_s_valid", 64'(s_axi_bvalid), 64'(2'b01 << r));
    chk_eq("b_s_resp", 64'(s_axi_bresp), 64'(resp) << (2 * r));
    chk_eq("b_m_ready", 64'(m_axi_bready), 64'd1);
    chk_eq("b_busy", 64'(busy), 64'd1);
    @(posedge aclk); #1;
    m_axi_bvalid    = 1'b0;
    m_axi_bresp     = 2'b00;
    s_axi_bready[r] = 1'b0;
    chk_eq("b_busy_fall", 64'(busy), 64'd0);
  endtask

  task automatic burst(input int r, input logic [31:0] addr, input logic [7:0] len,
                       input int mode, input int bad, input logic [1:0] resp);
    s_axi_awvalid[r]        = 1'b1;
    s_axi_awaddr[r*AW +: AW] = addr;
    s_axi_awlen[r*8 +: 8]   = len;
    aw_phase(r, addr, len);
    w_phase(r, len, mode, bad);
    b_phase(r, resp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single 4-beat burst from req0, AW latency of one cycle
    do_reset();
    s_axi_awvalid[0]   = 1'b1;
    s_axi_awaddr[31:0] = 32'h1000_0000;
    s_axi_awlen[7:0]   = 8'd3;
    #1;
    chk_eq("aw_not_yet", 64'(m_axi_awvalid), 64'd0);
    @(posedge aclk); #1;
    chk_eq("aw_latency", 64'(m_axi_awvalid), 64'd1);
    aw_phase(0, 32'h1000_0000, 8'd3);
    w_phase(0, 8'd3, 0, -1);
    b_phase(0, 2'b00);

    // Simultaneous requests alternate starting with req0
    do_reset();
    s_axi_awvalid[1] = 1'b1;
    s_axi_awaddr[63:32] = 32'h2000_0000;
    s_axi_awlen[15:8]   = 8'd1;
    burst(0, 32'h1000_0040, 8'd1, 0, -1, 2'b00);
    burst(1, 32'h2000_0000, 8'd1, 0, -1, 2'b10);
    s_axi_awvalid[1] = 1'b1;
    burst(0, 32'h1000_0080, 8'd2, 0, -1, 2'b00);
    burst(1, 32'h2000_0000, 8'd1, 0, -1, 2'b00);

    // Throttled W channel
    burst(0, 32'h1000_1000, 8'd7, 1, -1, 2'b00);

    // Maximum burst length
    burst(1, 32'h2000_2000, 8'd255, 0, -1, 2'b00);

    // Reset during beat 2 abandons the burst
    do_reset();
    s_axi_awvalid[0]   = 1'b1;
    s_axi_awaddr[31:0] = 32'h1000_3000;
    s_axi_awlen[7:0]   = 8'd3;
    aw_phase(0, 32'h1000_3000, 8'd3);
    s_axi_wvalid[0] = 1'b1;
    m_axi_wready    = 1'b1;
    @(posedge aclk); #1;
    chk_eq("mid_beat2_valid", 64'(m_axi_wvalid), 64'd1);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    chk_eq("mid_rst_busy", 64'(busy), 64'd0);
    chk_eq("mid_rst_m_awvalid", 64'(m_axi_awvalid), 64'd0);
    chk_eq("mid_rst_m_wvalid", 64'(m_axi_wvalid), 64'd0);
    chk_eq("mid_rst_m_bready", 64'(m_axi_bready), 64'd0);
    chk_eq("mid_rst_s_wready", 64'(s_axi_wready), 64'd0);
    chk_eq("mid_rst_s_awready", 64'(s_axi_awready), 64'd0);
    chk_eq("mid_rst_s_bvalid", 64'(s_axi_bvalid), 64'd0);
    s_axi_wvalid = '0;
    m_axi_wready = 1'b0;
    aresetn      = 1'b1;
    @(posedge aclk); #1;
    burst(1, 32'h2000_4000, 8'd0, 0, -1, 2'b00);

`ifdef AXI_ARB_WLAST_CHECK_EN
    // Early requester wlast on beat 2 sets the sticky error
    do_reset();
    chk_eq("wlast_err_rst", 64'(wlast_err), 64'd0);
    burst(0, 32'h1000_5000, 8'd3, 0, -1, 2'b00);
    chk_eq("wlast_err_clean", 64'(wlast_err), 64'd0);
    burst(1, 32'h2000_5000, 8'd3, 0, 1, 2'b00);
    chk_eq("wlast_err_set", 64'(wlast_err), 64'd1);
    burst(0, 32'h1000_6000, 8'd1, 0, -1, 2'b00);
    chk_eq("wlast_err_sticky", 64'(wlast_err), 64'd1);
    do_reset();
    chk_eq("wlast_err_cleared", 64'(wlast_err), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
